vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port capture VRAM (16-bit address = {ypos, xpos}, 2-bit pixel) between two users.
- User 1 is the video sampler's write stream: at most one write per clock, and it cannot be stalled.
- User 2 is a stallable read requester (output scaler / readout logic) using a req/ack handshake.
- Sits between the sampler outputs and the VRAM macro, in the sampler clock domain.
- A small write FIFO absorbs sampler writes displaced by forced reads. Reads are forwarded from pending FIFO entries, so readers never see stale pixels.

Parameters:
- DEPTH, 4: write FIFO entries; power of two, minimum 2.
- MAX_WAIT, 8: cycles a read may wait before it preempts the write stream (1..255).

Ports:
- rgb_clk  in  1  sole clock (VRAM clock).
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  sampler write strobe.
- wr_addr  in  16  sampler write address.
- wr_data  in  2  sampler pixel.
- rd_req  in  1  read request; held with rd_addr stable until rd_ack.
- rd_addr  in  16  read address.
- rd_ack  out  1  read granted this cycle.
- rd_valid  out  1  read data valid (one cycle after rd_ack).
- rd_data  out  2  read pixel.
- ram_addr  out  16  VRAM address.
- ram_wdata  out  2  VRAM write data.
- ram_we  out  1  VRAM write enable.
- ram_rdata  in  2  VRAM read data; synchronous, 1-cycle latency.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at a rgb_clk edge):
  - FIFO emptied and wait_cnt cleared.
  - rd_ack, rd_valid, ram_we, fifo_level go to 0; rd_data, ram_addr, ram_wdata go to 0.
  - A read acked in the reset cycle produces no rd_valid.
  - Writes in flight or in the FIFO are discarded.
- Write candidate (wc): FIFO head if level > 0; otherwise the incoming write if wr_en (bypass); otherwise none.
- Grant, evaluated combinationally each cycle, exactly one VRAM op per cycle:
  - READ if rd_req and (wc is none, or (wait_cnt >= MAX_WAIT and level < DEPTH)).
  - Otherwise WRITE if wc exists.
  - Otherwise IDLE.
- READ cycle:
  - ram_addr = rd_addr, ram_we = 0, rd_ack = 1.
  - If wr_en, the incoming write is pushed to the FIFO.
- WRITE cycle:
  - ram_addr/ram_wdata = wc, ram_we = 1.
  - If wc is the FIFO head, pop it. A simultaneous wr_en pushes, so level is unchanged.
- rd_ack and ram_* are combinational outputs of the grant logic.
- rd_valid is registered: high exactly one cycle after rd_ack.
- rd_data:
  - If any FIFO entry (after this cycle's push/pop) matches the read address at grant, return the newest matching entry's data, captured in a register at grant.
  - Otherwise return ram_rdata.
  - A write to the same address in the same grant cycle is pushed, so it is forwarded.
- wait_cnt (8-bit, saturating):
  - Increments each cycle rd_req is high and rd_ack is low.
  - Clears on rd_ack or when rd_req is low.
- FIFO:
  - Ordered; writes reach VRAM in sampler order.
  - Overflow is impossible by construction, since a forced read requires level < DEPTH.
  - With level = DEPTH, reads wait until wr_en drops and the FIFO drains below DEPTH.
- Drain: while wr_en is low and no read is granted, the FIFO pops one entry per cycle.
- rd_req dropped before ack is legal; no ack or valid is produced.

Decomposition:
- Package vram_pkg:
  - VRAM_AW = 16, VRAM_DW = 2.
  - Typedef vram_wr_t {addr[15:0], data[1:0]}.
  - Grant enum {GNT_IDLE, GNT_WR, GNT_RD}.
- Sub-module vram_wrfifo:
  - DEPTH-entry register FIFO with push, pop, level and head.
  - Exposes all entries plus valid bits for the forwarding compare.
  - Simultaneous push+pop at full or empty is legal; at empty this is a bypass handled by the parent.

Test Plan:
1. Idle read: VRAM[0x1234]=2, no wr_en, rd_req addr 0x1234 -> rd_ack same cycle, ram_we=0, rd_valid next cycle with rd_data=2.
2. Bypass write: wr_en addr 0x0100 data 3, no rd_req -> ram_we=1, ram_addr=0x0100, ram_wdata=3 same cycle; fifo_level stays 0.
3. Forced read: wr_en continuous 160 cycles from t0, rd_req addr 0x2000 from t0+10, MAX_WAIT=8 -> rd_ack at t0+18, fifo_level=1 thereafter; level returns to 0 one cycle after wr_en drops; all 160 writes land in order.
4. Forwarding: a forced read to 0x0005 coincides with an incoming write 0x0005=1 while VRAM holds 0 -> rd_data=1.
5. FIFO full: DEPTH=4, five reads forced during one burst -> level reaches 4; fifth rd_ack only after wr_en low and level < 4; no write lost.
6. Reset mid-burst at level 3 with rd_ack asserted -> next cycle fifo_level=0, ram_we=0, rd_valid=0.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the capture VRAM arbiter.
//   VRAM_AW / VRAM_DW : VRAM address and pixel widths.
//   vram_wr_t         : one pending pixel write (address + data).
//   vram_gnt_t        : which operation owns the single VRAM port this cycle.
package vram_pkg;

   localparam int VRAM_AW = 16;
   localparam int VRAM_DW = 2;

   typedef struct packed {
      logic [VRAM_AW-1:0] addr;
      logic [VRAM_DW-1:0] data;
   } vram_wr_t;

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_WR,
      GNT_RD
   } vram_gnt_t;

endpackage

// File: rtl/vram_wrfifo.sv
// vram_wrfifo: small register FIFO holding sampler writes displaced by reads.
// Entries are kept compacted in age order: slot 0 is the head (oldest) and
// slot level-1 is the newest. A pop shifts every slot down by one.
// Ports:
//   rgb_clk, rst_n : clock, synchronous active-low reset
//   push, push_entry : append one write
//   pop            : drop the head (ignored when empty)
//   level          : occupancy 0..DEPTH
//   head           : oldest entry
//   entries        : all slots flattened, slot i at [i*EW +: EW]
//   entry_valid    : bit i set when slot i holds a live entry
module vram_wrfifo
   import vram_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int LW = $clog2(DEPTH) + 1,
   localparam int EW = VRAM_AW + VRAM_DW
)(
   input  logic                rgb_clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [EW-1:0]       push_entry,
   input  logic                pop,
   output logic [LW-1:0]       level,
   output logic [EW-1:0]       head,
   output logic [DEPTH*EW-1:0] entries,
   output logic [DEPTH-1:0]    entry_valid
);

   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   vram_wr_t      mem_reg  [DEPTH];
   vram_wr_t      mem_next [DEPTH];
   logic [LW-1:0] level_reg;
   logic [LW-1:0] level_next;
   logic [LW-1:0] wr_idx;
   logic          do_pop;
   logic          do_push;

   assign do_pop  = pop && (level_reg != '0);
   // A push into a full FIFO is only accepted alongside a pop.
   assign do_push = push && ((level_reg != FULL_LEVEL) || do_pop);
   // The new entry lands just above the last live slot after the shift.
   assign wr_idx  = level_reg - LW'(do_pop);

   assign level_next = level_reg - LW'(do_pop) + LW'(do_push);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         vram_wr_t shifted;
         if (gi < DEPTH - 1) begin : g_mid
            assign shifted = do_pop ? mem_reg[gi+1] : mem_reg[gi];
         end else begin : g_last
            assign shifted = mem_reg[gi];
         end
         assign mem_next[gi] = (do_push && (wr_idx == LW'(gi))) ? vram_wr_t'(push_entry) : shifted;
         assign entries[gi*EW +: EW] = mem_reg[gi];
         assign entry_valid[gi]      = LW'(gi) < level_reg;
      end
   endgenerate

   always_ff @(posedge rgb_clk) begin
      if (!rst_n) begin
         level_reg <= '0;
         mem_reg   <= '{default: '0};
      end else begin
         level_reg <= level_next;
         mem_reg   <= mem_next;
      end
   end

   assign level = level_reg;
   assign head  = mem_reg[0];

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port capture VRAM between the sampler's
// unstallable write stream and a stallable req/ack reader.
// Ports:
//   rgb_clk, rst_n           : clock, synchronous active-low reset
//   wr_en, wr_addr, wr_data  : sampler write stream (one per clock max)
//   rd_req, rd_addr, rd_ack  : read handshake (addr held until ack)
//   rd_valid, rd_data        : read response, one cycle after rd_ack
//   ram_addr, ram_wdata, ram_we, ram_rdata : VRAM port (1-cycle read)
//   fifo_level               : write FIFO occupancy
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8,
   localparam int LW = $clog2(DEPTH) + 1,
   localparam int EW = VRAM_AW + VRAM_DW
)(
   input  logic               rgb_clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [VRAM_AW-1:0] wr_addr,
   input  logic [VRAM_DW-1:0] wr_data,
   input  logic               rd_req,
   input  logic [VRAM_AW-1:0] rd_addr,
   output logic               rd_ack,
   output logic               rd_valid,
   output logic [VRAM_DW-1:0] rd_data,
   output logic [VRAM_AW-1:0] ram_addr,
   output logic [VRAM_DW-1:0] ram_wdata,
   output logic               ram_we,
   input  logic [VRAM_DW-1:0] ram_rdata,
   output logic [LW-1:0]      fifo_level
);

   localparam logic [7:0]    MAX_WAIT_C = 8'(MAX_WAIT);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   vram_gnt_t          gnt;
   vram_wr_t           in_wr;
   vram_wr_t           head_wr;
   vram_wr_t           wc;
   vram_wr_t           fifo_ent [DEPTH];
   logic [EW-1:0]      fifo_head;
   logic [DEPTH*EW-1:0] fifo_entries;
   logic [DEPTH-1:0]   fifo_valid;
   logic [LW-1:0]      level;
   logic               fifo_nonempty;
   logic               wc_valid;
   logic               forced;
   logic               push;
   logic               pop;

   logic [7:0]         wait_cnt_reg, wait_cnt_next;
   logic               rd_valid_reg;
   logic               fwd_hit_reg, fwd_hit_next;
   logic [VRAM_DW-1:0] fwd_data_reg, fwd_data_next;

   vram_wrfifo #(.DEPTH(DEPTH)) u_wrfifo (
      .rgb_clk     (rgb_clk),
      .rst_n       (rst_n),
      .push        (push),
      .push_entry  (in_wr),
      .pop         (pop),
      .level       (level),
      .head        (fifo_head),
      .entries     (fifo_entries),
      .entry_valid (fifo_valid)
   );

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_ent
         assign fifo_ent[gi] = fifo_entries[gi*EW +: EW];
      end
   endgenerate

   assign in_wr         = '{addr: wr_addr, data: wr_data};
   assign head_wr       = fifo_head;
   assign fifo_nonempty = (level != '0);
   // Queued writes always go first so VRAM sees them in sampler order.
   assign wc            = fifo_nonempty ? head_wr : in_wr;
   assign wc_valid      = fifo_nonempty || wr_en;
   // A read may only displace the stream if the FIFO has room for the
   // write it displaces.
   assign forced        = (wait_cnt_reg >= MAX_WAIT_C) && (level < FULL_LEVEL);

   always_comb begin
      gnt = GNT_IDLE;
      if (rd_req && (!wc_valid || forced)) begin
         gnt = GNT_RD;
      end else if (wc_valid) begin
         gnt = GNT_WR;
      end
   end

   always_comb begin
      rd_ack    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      push      = 1'b0;
      pop       = 1'b0;
      case (gnt)
         GNT_RD: begin
            rd_ack   = 1'b1;
            ram_addr = rd_addr;
            push     = wr_en;
         end
         GNT_WR: begin
            ram_we    = 1'b1;
            ram_addr  = wc.addr;
            ram_wdata = wc.data;
            // With an empty FIFO the incoming write bypasses it entirely.
            pop       = fifo_nonempty;
            push      = fifo_nonempty && wr_en;
         end
         default: ;
      endcase
   end

   // Forwarding only matters on a read grant, where nothing is popped, so the
   // post-cycle contents are the live slots plus this cycle's incoming write.
   // Scanning oldest to newest lets the newest match win.
   always_comb begin
      fwd_hit_next  = 1'b0;
      fwd_data_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_valid[i] && (fifo_ent[i].addr == rd_addr)) begin
            fwd_hit_next  = 1'b1;
            fwd_data_next = fifo_ent[i].data;
         end
      end
      if (wr_en && (wr_addr == rd_addr)) begin
         fwd_hit_next  = 1'b1;
         fwd_data_next = wr_data;
      end
   end

   always_comb begin
      wait_cnt_next = '0;
      if (rd_req && !rd_ack) begin
         wait_cnt_next = (wait_cnt_reg == 8'hff) ? 8'hff : wait_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge rgb_clk) begin
      if (!rst_n) begin
         wait_cnt_reg <= '0;
         rd_valid_reg <= 1'b0;
         fwd_hit_reg  <= 1'b0;
         fwd_data_reg <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         rd_valid_reg <= rd_ack;
         fwd_hit_reg  <= rd_ack && fwd_hit_next;
         fwd_data_reg <= fwd_data_next;
      end
   end

   assign rd_valid   = rd_valid_reg;
   assign rd_data    = rd_valid_reg ? (fwd_hit_reg ? fwd_data_reg : ram_rdata) : '0;
   assign fifo_level = level;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

   localparam int DEPTH    = 4;
   localparam int MAX_WAIT = 8;
   localparam int LW       = $clog2(DEPTH) + 1;

   logic          rgb_clk = 1'b0;
   logic          rst_n   = 1'b0;
   logic          wr_en   = 1'b0;
   logic [15:0]   wr_addr = '0;
   logic [1:0]    wr_data = '0;
   logic          rd_req  = 1'b0;
   logic [15:0]   rd_addr = '0;
   logic          rd_ack;
   logic          rd_valid;
   logic [1:0]    rd_data;
   logic [15:0]   ram_addr;
   logic [1:0]    ram_wdata;
   logic          ram_we;
   logic [1:0]    ram_rdata = '0;
   logic [LW-1:0] fifo_level;

   int errors = 0;
   int checks = 0;

   // VRAM macro model plus the reference view of memory:
   // logical_mem = every write the sampler has issued (what a reader must see)
   // committed_mem = what has actually reached the VRAM port.
   logic [1:0] vram          [65536];
   logic [1:0] logical_mem   [65536];
   logic [1:0] committed_mem [65536];

   typedef struct {
      logic [15:0] a;
      logic [1:0]  d;
   } wr_t;

   wr_t        wq[$];
   logic [1:0] rq[$];
   int         tb_wait  = 0;
   logic       prev_ack = 1'b0;
   logic       exp_ack;
   logic [1:0] exp_rd;
   wr_t        exp_wr;
   logic       was_reset = 1'b1;

   always #5 rgb_clk = ~rgb_clk;

   vram_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .rgb_clk    (rgb_clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_ack     (rd_ack),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata),
      .fifo_level (fifo_level)
   );

   always @(posedge rgb_clk) begin
      ram_rdata <= vram[ram_addr];
      if (ram_we) vram[ram_addr] = ram_wdata;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor / scoreboard: consumes DUT outputs every cycle.
   always @(negedge rgb_clk) begin
      if (!rst_n) begin
         if (ram_we) committed_mem[ram_addr] = ram_wdata;
         prev_ack = 1'b0;
         tb_wait  = 0;
      end else begin
         // Writes issued but not yet landed before this cycle.
         chk("fifo_level", 32'(fifo_level), 32'(wq.size() - (wr_en ? 1 : 0)));
         exp_ack = rd_req && (((fifo_level == 0) && !wr_en) ||
                              ((tb_wait >= MAX_WAIT) && (fifo_level < DEPTH)));
         chk("rd_ack", 32'(rd_ack), 32'(exp_ack));
         chk("rd_valid", 32'(rd_valid), 32'(prev_ack));
         if (rd_valid) begin
            if (rq.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected: got data %0h expected no response", rd_data);
            end else begin
               exp_rd = rq.pop_front();
               chk("rd_data", 32'(rd_data), 32'(exp_rd));
            end
         end
         if (ram_we) begin
            if (wq.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_unexpected: got addr %0h expected no write", ram_addr);
            end else begin
               exp_wr = wq.pop_front();
               chk("wr_addr", 32'(ram_addr), 32'(exp_wr.a));
               chk("wr_data", 32'(ram_wdata), 32'(exp_wr.d));
               committed_mem[exp_wr.a] = exp_wr.d;
            end
         end
         if (rd_ack) rq.push_back(logical_mem[rd_addr]);
         tb_wait  = (rd_req && !rd_ack) ? tb_wait + 1 : 0;
         prev_ack = rd_ack;
      end
   end

   task automatic drive(input logic rst, input logic we, input logic [15:0] wa,
                        input logic [1:0] wd, input logic rq_, input logic [15:0] ra);
      @(posedge rgb_clk);
      #1;
      if (rst && was_reset) begin
         for (int i = 0; i < 65536; i++) logical_mem[i] = committed_mem[i];
      end
      was_reset = !rst;
      rst_n   = rst;
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      rd_req  = rq_;
      rd_addr = ra;
      if (!rst) begin
         wq.delete();
         rq.delete();
      end else if (we) begin
         wq.push_back('{a: wa, d: wd});
         logical_mem[wa] = wd;
      end
      @(negedge rgb_clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_cyc, nreads, max_lvl, fifth_cyc, fifth_lvl;
      logic acked, fifth_we, rd_out;
      logic [15:0] ra, wa;
      int mode_left, wr_mode;

      for (int i = 0; i < 65536; i++) begin
         vram[i] = '0; logical_mem[i] = '0; committed_mem[i] = '0;
      end
      vram[16'h1234] = 2'd2; logical_mem[16'h1234] = 2'd2; committed_mem[16'h1234] = 2'd2;

      // Reset state
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
      drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
      chk("rst_rd_ack", 32'(rd_ack), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);

      // 1: idle read
      drive(1'b1, 1'b0, '0, '0, 1'b1, 16'h1234);
      chk("t1_ack", 32'(rd_ack), 1);
      chk("t1_we", 32'(ram_we), 0);
      chk("t1_addr", 32'(ram_addr), 32'h1234);
      idle(1);
      chk("t1_valid", 32'(rd_valid), 1);
      chk("t1_data", 32'(rd_data), 2);

      // 2: bypass write
      drive(1'b1, 1'b1, 16'h0100, 2'd3, 1'b0, '0);
      chk("t2_we", 32'(ram_we), 1);
      chk("t2_addr", 32'(ram_addr), 32'h0100);
      chk("t2_wdata", 32'(ram_wdata), 3);
      chk("t2_level", 32'(fifo_level), 0);
      idle(1);
      chk("t2_level_after", 32'(fifo_level), 0);

      // 3: forced read during a 160-write burst
      ack_cyc = -1; acked = 1'b0;
      for (int i = 0; i < 166; i++) begin
         drive(1'b1, i < 160, 16'h4000 + 16'(i), 2'(i), (i >= 10) && !acked, 16'h2000);
         if (rd_req && rd_ack) begin ack_cyc = i; acked = 1'b1; end
         if (i == 19 || i == 100) chk("t3_level_one", 32'(fifo_level), 1);
         if (i == 161) chk("t3_level_drained", 32'(fifo_level), 0);
      end
      chk("t3_ack_cycle", 32'(ack_cyc), 18);
      chk("t3_all_landed", 32'(wq.size()), 0);

      // 4: forced read coincides with a write to the same address
      ack_cyc = -1; acked = 1'b0;
      for (int i = 0; i < 22; i++) begin
         wa = (i == 8) ? 16'h0005 : 16'h5000 + 16'(i);
         drive(1'b1, i < 16, wa, (i == 8) ? 2'd1 : 2'd2, !acked, 16'h0005);
         if (acked && i == ack_cyc + 1) begin
            chk("t4_valid", 32'(rd_valid), 1);
            chk("t4_fwd_data", 32'(rd_data), 1);
         end
         if (rd_req && rd_ack) begin ack_cyc = i; acked = 1'b1; end
      end
      chk("t4_ack_cycle", 32'(ack_cyc), 8);

      // 5: five reads during one burst fill the FIFO
      nreads = 0; max_lvl = 0; fifth_cyc = -1; fifth_lvl = 99; fifth_we = 1'b1;
      for (int i = 0; i < 80; i++) begin
         drive(1'b1, i < 60, 16'h6000 + 16'(i), 2'(i + 1), nreads < 5, 16'h6000 + 16'(nreads * 3));
         if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
         if (rd_req && rd_ack) begin
            if (nreads == 4) begin fifth_cyc = i; fifth_lvl = int'(fifo_level); fifth_we = wr_en; end
            nreads++;
         end
      end
      chk("t5_reads", 32'(nreads), 5);
      chk("t5_max_level", 32'(max_lvl), 4);
      chk("t5_fifth_wr_low", 32'(fifth_we), 0);
      chk("t5_fifth_level_room", 32'(fifth_lvl < DEPTH), 1);
      chk("t5_fifth_cycle", 32'(fifth_cyc), 61);
      chk("t5_all_landed", 32'(wq.size()), 0);

      // 6: reset mid-burst at level 3 while a read is being acked
      nreads = 0;
      for (int i = 0; i < 36; i++) begin
         drive(i != 35, 1'b1, 16'h7000 + 16'(i), 2'(i), 1'b1, 16'h7100 + 16'(nreads));
         if (rd_req && rd_ack) nreads++;
      end
      chk("t6_ack_in_reset", 32'(rd_ack), 1);
      chk("t6_level_in_reset", 32'(fifo_level), 3);
      idle(1);
      chk("t6_level", 32'(fifo_level), 0);
      chk("t6_we", 32'(ram_we), 0);
      chk("t6_valid", 32'(rd_valid), 0);
      chk("t6_rd_data", 32'(rd_data), 0);
      idle(3);

      // Randomized traffic over a small address window to stress forwarding
      rd_out = 1'b0; ra = '0; mode_left = 0; wr_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         if (mode_left == 0) begin
            mode_left = int'($urandom_range(1, 40));
            wr_mode   = int'($urandom_range(0, 2));
         end
         mode_left--;
         if (!rd_out && $urandom_range(0, 3) == 0) begin
            rd_out = 1'b1; ra = 16'($urandom_range(0, 15));
         end else if (rd_out && $urandom_range(0, 49) == 0) begin
            rd_out = 1'b0;
         end
         drive(1'b1,
               (wr_mode == 2) || ((wr_mode == 1) && ($urandom_range(0, 3) == 0)),
               16'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), rd_out, ra);
         if (rd_req && rd_ack) rd_out = 1'b0;
      end

      for (int i = 0; i < 20 && wq.size() != 0; i++) idle(1);
      idle(2);
      chk("final_writes_landed", 32'(wq.size()), 0);
      chk("final_reads_answered", 32'(rq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
